// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C target with memory-mapped register interface
// Ports: clk_i/rst_i (sync, active-high); write_i, data_be_i, addr_i, wdata_i -> register writes;
//        rdata_o combinational register read at addr_i; sda_io open-drain data; scl_i bus clock.
// Optional: define I2C_SLAVE_FILTER_EN to add a 3-sample stability filter on SCL and SDA.
module i2c_slave #(
    parameter logic [6:0] RST_ADDR    = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        write_i,
    input  logic [3:0]  data_be_i,
    input  logic [4:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    inout  wire         sda_io,
    input  logic        scl_i
);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_IGNORE, S_ACK_A, S_RX, S_ACK_R, S_NACK_R, S_TX, S_ACK_T
    } state_t;

    logic                   sda_in;
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic                   scl_c, sda_c, scl_prev_q, sda_prev_q;

    assign sda_in     = sda_io;
    assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};

`ifdef I2C_SLAVE_FILTER_EN
    logic [1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
    logic       scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;
    logic       scl_raw, sda_raw;

    // The filtered level only follows the raw level after three equal samples in a row.
    always_comb begin
        scl_raw    = scl_sync_q[SYNC_STAGES-1];
        sda_raw    = sda_sync_q[SYNC_STAGES-1];
        scl_hist_d = {scl_hist_q[0], scl_raw};
        sda_hist_d = {sda_hist_q[0], sda_raw};
        scl_filt_d = (scl_hist_q == {2{scl_raw}}) ? scl_raw : scl_filt_q;
        sda_filt_d = (sda_hist_q == {2{sda_raw}}) ? sda_raw : sda_filt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
            scl_filt_q <= scl_filt_d;
            sda_filt_q <= sda_filt_d;
        end
    end

    assign scl_c = scl_filt_q;
    assign sda_c = sda_filt_q;
`else
    assign scl_c = scl_sync_q[SYNC_STAGES-1];
    assign sda_c = sda_sync_q[SYNC_STAGES-1];
`endif

    logic scl_rise, scl_fall, bus_start, bus_stop;
    assign scl_rise  = scl_c & ~scl_prev_q;
    assign scl_fall  = ~scl_c & scl_prev_q;
    assign bus_start = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
    assign bus_stop  = scl_c & scl_prev_q & ~sda_prev_q & sda_c;

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  sr_q, sr_d;
    logic [2:0]  idx_q, idx_d, cnt_q, cnt_d, nby_q, nby_d;
    logic        rw_q, rw_d, ph_q, ph_d, data_q, data_d, oe_q, oe_d;
    logic [6:0]  adr_q, adr_d;
    logic [31:0] rdr_q, rdr_d, tdr_q, tdr_d;
    logic        rx_done_q, rx_done_d, tx_done_q, tx_done_d, ovf_q, ovf_d;
    logic [7:0]  rx_byte, tx_sel;
    logic        busy;

    assign rx_byte = {sr_q[6:0], sda_c};
    // Byte index 4 means past the end of TDR: send all ones, i.e. leave SDA released.
    assign tx_sel  = idx_q[2] ? 8'hFF : tdr_q[{idx_q[1:0], 3'b000} +: 8];
    assign busy    = (state_q != S_IDLE);
    assign sda_io  = oe_q ? 1'b0 : 1'bz;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        nby_d     = nby_q;
        rw_d      = rw_q;
        ph_d      = ph_q;
        data_d    = data_q;
        oe_d      = oe_q;
        adr_d     = adr_q;
        rdr_d     = rdr_q;
        tdr_d     = tdr_q;
        rx_done_d = rx_done_q;
        tx_done_d = tx_done_q;
        ovf_d     = ovf_q;

        // Bus writes first so that hardware status sets below take priority over clears.
        if (write_i) begin
            case (addr_i)
                5'd0:  if (data_be_i[0]) adr_d = wdata_i[6:0];
                5'd8:  for (int b = 0; b < 4; b++)
                           if (data_be_i[b]) tdr_d[8*b +: 8] = wdata_i[8*b +: 8];
                5'd16: if (data_be_i[0]) begin
                           if (wdata_i[1]) rx_done_d = 1'b0;
                           if (wdata_i[2]) tx_done_d = 1'b0;
                           if (wdata_i[3]) ovf_d     = 1'b0;
                       end
                default: ;
            endcase
        end

        if (bus_start) begin
            state_d   = S_ADDR;
            bit_cnt_d = 4'd0;
            idx_d     = 3'd0;
            cnt_d     = 3'd0;
            data_d    = 1'b0;
            oe_d      = 1'b0;
            ph_d      = 1'b0;
        end else if (bus_stop) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
            data_d  = 1'b0;
            if (data_q) begin
                nby_d = cnt_q;
                if (rw_q) tx_done_d = 1'b1;
                else      rx_done_d = 1'b1;
            end
        end else begin
            case (state_q)
                S_ADDR: if (scl_rise) begin
                    sr_d      = rx_byte;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        rw_d    = sda_c;
                        ph_d    = 1'b0;
                        state_d = (sr_q[6:0] == adr_q) ? S_ACK_A : S_IGNORE;
                    end
                end
                // ph marks that the master has clocked the ack bit; the fall after it ends the slot.
                S_ACK_A: begin
                    if (scl_rise) ph_d = 1'b1;
                    if (scl_fall) begin
                        if (!ph_q) oe_d = 1'b1;
                        else begin
                            data_d    = 1'b1;
                            bit_cnt_d = 4'd0;
                            if (rw_q) begin
                                sr_d    = tx_sel;
                                oe_d    = ~tx_sel[7];
                                state_d = S_TX;
                            end else begin
                                oe_d    = 1'b0;
                                state_d = S_RX;
                            end
                        end
                    end
                end
                S_RX: if (scl_rise) begin
                    sr_d      = rx_byte;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        ph_d = 1'b0;
                        if (!idx_q[2]) begin
                            rdr_d[{idx_q[1:0], 3'b000} +: 8] = rx_byte;
                            idx_d   = idx_q + 3'd1;
                            cnt_d   = cnt_q + 3'd1;
                            state_d = S_ACK_R;
                        end else begin
                            ovf_d   = 1'b1;
                            state_d = S_NACK_R;
                        end
                    end
                end
                S_ACK_R, S_NACK_R: begin
                    if (scl_rise) ph_d = 1'b1;
                    if (scl_fall) begin
                        if (!ph_q) oe_d = (state_q == S_ACK_R);
                        else begin
                            oe_d      = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = S_RX;
                        end
                    end
                end
                // Shift after the master's sampling edge; the next bit is put out on the fall.
                S_TX: begin
                    if (scl_rise) begin
                        sr_d      = {sr_q[6:0], 1'b1};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            ph_d    = 1'b0;
                            state_d = S_ACK_T;
                        end else begin
                            oe_d = ~sr_q[7];
                        end
                    end
                end
                S_ACK_T: begin
                    if (scl_rise) begin
                        ph_d = 1'b1;
                        if (!cnt_q[2]) cnt_d = cnt_q + 3'd1;
                        if (sda_c) state_d = S_IGNORE;
                        else if (idx_q < 3'd3) idx_d = idx_q + 3'd1;
                        else begin
                            ovf_d = 1'b1;
                            idx_d = 3'd4;
                        end
                    end
                    if (scl_fall && ph_q) begin
                        sr_d      = tx_sel;
                        oe_d      = ~tx_sel[7];
                        bit_cnt_d = 4'd0;
                        state_d   = S_TX;
                    end
                end
                S_IGNORE: oe_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            bit_cnt_q  <= 4'd0;
            sr_q       <= 8'd0;
            idx_q      <= 3'd0;
            cnt_q      <= 3'd0;
            nby_q      <= 3'd0;
            rw_q       <= 1'b0;
            ph_q       <= 1'b0;
            data_q     <= 1'b0;
            oe_q       <= 1'b0;
            adr_q      <= RST_ADDR;
            rdr_q      <= 32'd0;
            tdr_q      <= 32'd0;
            rx_done_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_c;
            sda_prev_q <= sda_c;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sr_q       <= sr_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            nby_q      <= nby_d;
            rw_q       <= rw_d;
            ph_q       <= ph_d;
            data_q     <= data_d;
            oe_q       <= oe_d;
            adr_q      <= adr_d;
            rdr_q      <= rdr_d;
            tdr_q      <= tdr_d;
            rx_done_q  <= rx_done_d;
            tx_done_q  <= tx_done_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        case (addr_i)
            5'd0:    rdata_o = {25'd0, adr_q};
            5'd4:    rdata_o = rdr_q;
            5'd8:    rdata_o = tdr_q;
            5'd12:   rdata_o = {29'd0, nby_q};
            5'd16:   rdata_o = {28'd0, ovf_q, tx_done_q, rx_done_q, busy};
            default: rdata_o = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - directed bench for i2c_slave acting as an I2C bus master
module tb_i2c_slave;
    localparam int Q = 8;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        write_i;
    logic [3:0]  data_be_i;
    logic [4:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        scl;
    logic        m_low;
    wire         sda;

    int tests_run    = 0;
    int tests_failed = 0;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .write_i   (write_i),
        .data_be_i (data_be_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .rdata_o   (rdata_o),
        .sda_io    (sda),
        .scl_i     (scl)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic reg_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        addr_i = a; wdata_i = d; data_be_i = be; write_i = 1'b1;
        @(negedge clk);
        write_i = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        @(negedge clk);
        addr_i = a;
        #1 d = rdata_o;
        check(tag, d, exp);
    endtask

    task automatic send_bit(input logic b);
        m_low = ~b; wq(); scl = 1'b1; wq(); wq(); scl = 1'b0; wq();
    endtask

    task automatic read_bit(output logic b);
        m_low = 1'b0; wq(); scl = 1'b1; wq(); b = sda; wq(); scl = 1'b0; wq();
    endtask

    // Works from idle and as a repeated START with SCL low.
    task automatic bus_start();
        m_low = 1'b0; wq(); scl = 1'b1; wq(); m_low = 1'b1; wq(); scl = 1'b0; wq();
    endtask

    task automatic bus_stop();
        m_low = 1'b1; wq(); scl = 1'b1; wq(); m_low = 1'b0; wq();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] b, input logic ack);
        logic bit_v;
        for (int i = 7; i >= 0; i--) begin
            read_bit(bit_v);
            b[i] = bit_v;
        end
        send_bit(ack);
    endtask

    logic       ack;
    logic [7:0] rb;
    logic [7:0] wr5 [5];

    initial begin
        rst_i = 1'b1; write_i = 1'b0; data_be_i = 4'h0; addr_i = 5'd0; wdata_i = 32'd0;
        scl = 1'b1; m_low = 1'b0;
        repeat (5) @(negedge clk);
        rst_i = 1'b0;
        repeat (5) @(negedge clk);

        chk_reg("rst_adr", 5'd0, 32'h42);
        chk_reg("rst_sts", 5'd16, 32'h0);
        chk_reg("rst_rdr", 5'd4, 32'h0);
        chk_reg("rst_nby", 5'd12, 32'h0);
        chk_reg("unmapped", 5'd20, 32'h0);
        check("rst_sda", {31'd0, sda}, 32'd1);
        reg_wr(5'd0, 32'h7F, 4'h0);
        chk_reg("adr_be0", 5'd0, 32'h42);

        // Write two bytes
        bus_start();
        write_byte(8'h84, ack); check("w_addr_ack", {31'd0, ack}, 32'd0);
        chk_reg("w_busy", 5'd16, 32'h1);
        write_byte(8'hA5, ack); check("w_b0_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h3C, ack); check("w_b1_ack", {31'd0, ack}, 32'd0);
        bus_stop();
        wq();
        chk_reg("w_rdr", 5'd4, 32'h00003CA5);
        chk_reg("w_nby", 5'd12, 32'd2);
        chk_reg("w_sts", 5'd16, 32'h2);
        reg_wr(5'd16, 32'hE, 4'h1);
        chk_reg("w_sts_clr", 5'd16, 32'h0);

        // Read three bytes, last one NACKed
        reg_wr(5'd8, 32'hDDCCBBAA, 4'hF);
        bus_start();
        write_byte(8'h85, ack); check("r_addr_ack", {31'd0, ack}, 32'd0);
        read_byte(rb, 1'b0); check("r_b0", {24'd0, rb}, 32'hAA);
        read_byte(rb, 1'b0); check("r_b1", {24'd0, rb}, 32'hBB);
        read_byte(rb, 1'b1); check("r_b2", {24'd0, rb}, 32'hCC);
        bus_stop();
        wq();
        chk_reg("r_nby", 5'd12, 32'd3);
        chk_reg("r_sts", 5'd16, 32'h4);
        reg_wr(5'd16, 32'hE, 4'h1);

        // Foreign address
        bus_start();
        write_byte(8'h86, ack); check("x_addr_nack", {31'd0, ack}, 32'd1);
        write_byte(8'h00, ack); check("x_data_nack", {31'd0, ack}, 32'd1);
        bus_stop();
        wq();
        chk_reg("x_sts", 5'd16, 32'h0);
        chk_reg("x_nby", 5'd12, 32'd3);

        // Five-byte write overflows
        wr5[0] = 8'h11; wr5[1] = 8'h22; wr5[2] = 8'h33; wr5[3] = 8'h44; wr5[4] = 8'h55;
        bus_start();
        write_byte(8'h84, ack); check("o_addr_ack", {31'd0, ack}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            write_byte(wr5[i], ack);
            check($sformatf("o_b%0d_ack", i), {31'd0, ack}, (i == 4) ? 32'd1 : 32'd0);
        end
        bus_stop();
        wq();
        chk_reg("o_nby", 5'd12, 32'd4);
        chk_reg("o_rdr", 5'd4, 32'h44332211);
        chk_reg("o_sts", 5'd16, 32'hA);
        reg_wr(5'd16, 32'h8, 4'h1);
        chk_reg("o_sts_clr", 5'd16, 32'h2);
        reg_wr(5'd16, 32'hE, 4'h1);

        // Write one byte, repeated START, read one byte
        reg_wr(5'd8, 32'h12345678, 4'hF);
        bus_start();
        write_byte(8'h84, ack); check("sr_waddr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h99, ack); check("sr_wb_ack", {31'd0, ack}, 32'd0);
        bus_start();
        write_byte(8'h85, ack); check("sr_raddr_ack", {31'd0, ack}, 32'd0);
        read_byte(rb, 1'b1); check("sr_rb", {24'd0, rb}, 32'h78);
        bus_stop();
        wq();
        chk_reg("sr_rdr", 5'd4, 32'h44332299);
        chk_reg("sr_nby", 5'd12, 32'd1);
        chk_reg("sr_sts", 5'd16, 32'h4);

        // Reset while the slave drives a 0 data bit
        bus_start();
        write_byte(8'h85, ack); check("rs_addr_ack", {31'd0, ack}, 32'd0);
        check("rs_sda_driven", {31'd0, sda}, 32'd0);
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1 check("rs_sda_rel", {31'd0, sda}, 32'd1);
        @(negedge clk);
        rst_i = 1'b0;
        chk_reg("rs_sts", 5'd16, 32'h0);
        chk_reg("rs_tdr", 5'd8, 32'h0);
        bus_stop();
        wq();
        chk_reg("rs_sts_idle", 5'd16, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
